// File: rtl/bh_pkg.sv
// Shared scene encoding and renderer geometry for the black-hole animation.
// Imported by the sequencer, its interface and the pixel datapath.
package bh_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'b00,
    ST_FALL    = 2'b01,
    ST_SWALLOW = 2'b10
  } scene_state_e;

  localparam int TOP_Y          = 20;
  localparam int HORIZON_Y      = 240;
  localparam int TEXT_H         = 32;
  localparam int SHADOW_BASE_R2 = 7225;
  localparam int SHADOW_STEP_R2 = 400;

  localparam int WAIT_FRAMES  = 128;
  localparam int VEL_MAX      = 8;
  localparam int PULSE_FRAMES = 16;

endpackage

// File: rtl/bh_scene_sequencer_if.sv
// Per-frame animation parameters handed from the sequencer to the renderer.
// frame_tick is the only strobe: it is a valid with no ready, high for one
// cycle when a new parameter set appears; every other field holds between strobes.
interface bh_scene_sequencer_if;
  import bh_pkg::*;

  logic         frame_tick;
  logic [15:0]  frame_cnt;
  logic [7:0]   tex_phase;
  logic [9:0]   text_y;
  logic         text_visible;
  logic [21:0]  shadow_r2;
  scene_state_e scene_state;

  modport master (
    output frame_tick, frame_cnt, tex_phase, text_y,
           text_visible, shadow_r2, scene_state
  );

  modport slave (
    input frame_tick, frame_cnt, tex_phase, text_y,
          text_visible, shadow_r2, scene_state
  );
endinterface

// File: rtl/bh_input_sync.sv
// Two-flop synchroniser for asynchronous UI levels, with a rising-edge
// detect on one selected bit taken after synchronisation.
module bh_input_sync #(
  parameter int W        = 4,
  parameter int EDGE_BIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic         rise_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q[EDGE_BIT];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q[EDGE_BIT] & ~prev_q;

endmodule

// File: rtl/bh_scene_sequencer.sv
// Frame-synchronous scene controller: text waits, falls into the hole, the
// shadow pulses, then the scene restarts. Parameters change only on a frame advance.
module bh_scene_sequencer
  import bh_pkg::*;
#(
  parameter int TOP_Y          = bh_pkg::TOP_Y,
  parameter int HORIZON_Y      = bh_pkg::HORIZON_Y,
  parameter int WAIT_FRAMES    = bh_pkg::WAIT_FRAMES,
  parameter int VEL_MAX        = bh_pkg::VEL_MAX,
  parameter int PULSE_FRAMES   = bh_pkg::PULSE_FRAMES,
  parameter int SHADOW_BASE_R2 = bh_pkg::SHADOW_BASE_R2,
  parameter int SHADOW_STEP_R2 = bh_pkg::SHADOW_STEP_R2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause_in,
  input  logic       step_in,
  input  logic [1:0] speed_in,
  bh_scene_sequencer_if.master seq_if
);

  localparam int WCW = (WAIT_FRAMES  > 1) ? $clog2(WAIT_FRAMES + 1) : 1;
  localparam int VW  = $clog2(VEL_MAX + 1);
  localparam int PW  = $clog2(PULSE_FRAMES + 1);

  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_FRAMES - 1);
  localparam logic [VW-1:0]  VEL_TOP    = VW'(VEL_MAX);
  localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_FRAMES);
  localparam logic [PW-1:0]  PULSE_HALF = PW'(PULSE_FRAMES / 2);
  localparam logic [10:0]    HORIZON_11 = 11'(HORIZON_Y);
  localparam logic [9:0]     HORIZON_10 = 10'(HORIZON_Y);
  localparam logic [9:0]     TOP_Y_10   = 10'(TOP_Y);
  localparam logic [21:0]    BASE_R2    = 22'(SHADOW_BASE_R2);
  localparam logic [21:0]    STEP_R2    = 22'(SHADOW_STEP_R2);

  logic [3:0] ui_s;
  logic       step_rise;
  logic       pause_s;
  logic [1:0] speed_s;
  logic       unused_step_level;

  bh_input_sync #(.W(4), .EDGE_BIT(1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i ({speed_in, step_in, pause_in}),
    .sync_o  (ui_s),
    .rise_o  (step_rise)
  );

  assign pause_s           = ui_s[0];
  assign unused_step_level = ui_s[1];
  assign speed_s           = ui_s[3:2];

  logic           vsync_q, vsync_d;
  logic           frame_tick_q, frame_tick_d;
  logic           step_pending_q, step_pending_d;
  scene_state_e   state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [VW-1:0]  vel_q, vel_d;
  logic [PW-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]     tex_phase_q, tex_phase_d;
  logic [9:0]     text_y_q, text_y_d;
  logic           text_visible_q, text_visible_d;
  logic [21:0]    shadow_r2_q, shadow_r2_d;

  logic          tick;
  logic          adv;
  logic [10:0]   y_sum;
  logic [PW-1:0] k;

  assign tick  = vsync_q & ~vsync;
  assign adv   = tick & (~pause_s | step_pending_q);
  assign y_sum = {1'b0, text_y_q} + 11'(vel_q);
  assign k     = pulse_cnt_q + PW'(1);

  always_comb begin
    vsync_d        = vsync;
    frame_tick_d   = tick;
    step_pending_d = step_pending_q;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    vel_d          = vel_q;
    pulse_cnt_d    = pulse_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    tex_phase_d    = tex_phase_q;
    text_y_d       = text_y_q;
    text_visible_d = text_visible_q;
    shadow_r2_d    = shadow_r2_q;

    // A single-step request is only armed while paused and is spent by the next frame.
    if (tick) begin
      step_pending_d = 1'b0;
    end else if (step_rise && pause_s) begin
      step_pending_d = 1'b1;
    end

    if (adv) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      tex_phase_d = tex_phase_q + 8'(speed_s) + 8'd1;
      case (state_q)
        ST_FALL: begin
          if (y_sum >= HORIZON_11) begin
            text_y_d       = HORIZON_10;
            text_visible_d = 1'b0;
            pulse_cnt_d    = '0;
            state_d        = ST_SWALLOW;
          end else begin
            text_y_d = y_sum[9:0];
            vel_d    = (vel_q == VEL_TOP) ? vel_q : vel_q + VW'(1);
          end
        end
        ST_SWALLOW: begin
          shadow_r2_d = (k <= PULSE_HALF) ? shadow_r2_q + STEP_R2
                                          : shadow_r2_q - STEP_R2;
          if (k == PULSE_LAST) begin
            shadow_r2_d    = BASE_R2;
            text_y_d       = TOP_Y_10;
            text_visible_d = 1'b1;
            vel_d          = '0;
            pulse_cnt_d    = '0;
            state_d        = ST_WAIT;
          end else begin
            pulse_cnt_d = k;
          end
        end
        // Covers ST_WAIT and the unused 2'b11 code so a corrupted state restarts the scene.
        default: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = '0;
            vel_d      = VW'(1);
            state_d    = ST_FALL;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
            state_d    = ST_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q        <= 1'b1;
      frame_tick_q   <= 1'b0;
      step_pending_q <= 1'b0;
      state_q        <= ST_WAIT;
      wait_cnt_q     <= '0;
      vel_q          <= '0;
      pulse_cnt_q    <= '0;
      frame_cnt_q    <= '0;
      tex_phase_q    <= '0;
      text_y_q       <= TOP_Y_10;
      text_visible_q <= 1'b1;
      shadow_r2_q    <= BASE_R2;
    end else begin
      vsync_q        <= vsync_d;
      frame_tick_q   <= frame_tick_d;
      step_pending_q <= step_pending_d;
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      vel_q          <= vel_d;
      pulse_cnt_q    <= pulse_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      tex_phase_q    <= tex_phase_d;
      text_y_q       <= text_y_d;
      text_visible_q <= text_visible_d;
      shadow_r2_q    <= shadow_r2_d;
    end
  end

  assign seq_if.frame_tick   = frame_tick_q;
  assign seq_if.frame_cnt    = frame_cnt_q;
  assign seq_if.tex_phase    = tex_phase_q;
  assign seq_if.text_y       = text_y_q;
  assign seq_if.text_visible = text_visible_q;
  assign seq_if.shadow_r2    = shadow_r2_q;
  assign seq_if.scene_state  = state_q;

endmodule

// File: tb/tb_bh_scene_sequencer.sv
// Randomised bench for bh_scene_sequencer: a scene table built from the fall and
// pulse rules predicts each frame's parameters, checked whenever frame_tick fires.
module tb_bh_scene_sequencer;

  localparam int WF    = 4;
  localparam int PF    = 16;
  localparam int VMAX  = 8;
  localparam int Y_TOP = 20;
  localparam int Y_HOR = 240;
  localparam int R2_B  = 7225;
  localparam int R2_S  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       pause_in = 1'b0;
  logic       step_in = 1'b0;
  logic [1:0] speed_in = 2'd0;

  bh_scene_sequencer_if seq_if ();

  bh_scene_sequencer #(.WAIT_FRAMES(WF), .PULSE_FRAMES(PF), .VEL_MAX(VMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (vsync),
    .pause_in (pause_in),
    .step_in  (step_in),
    .speed_in (speed_in),
    .seq_if   (seq_if)
  );

  // ---------------- clock / watchdog ----------------
  always #20 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [58:0] exp_q[$];

  // One entry per scene position = outputs after that many advances in the cycle.
  int t_y[$];
  int t_vis[$];
  int t_r2[$];
  int t_st[$];

  int m_idx;
  int m_frame;
  int m_phase;
  bit m_pause;
  bit m_step_pend;

  function automatic logic [58:0] pack(int fc, int ph, int y, int vis, int r2, int st);
    return {16'(fc), 8'(ph), 10'(y), 1'(vis), 22'(r2), 2'(st)};
  endfunction

  task automatic add_pos(int y, int vis, int r2, int st);
    t_y.push_back(y);
    t_vis.push_back(vis);
    t_r2.push_back(r2);
    t_st.push_back(st);
  endtask

  task automatic build_table();
    int y;
    int v;
    for (int i = 0; i < WF; i++) add_pos(Y_TOP, 1, R2_B, 0);
    add_pos(Y_TOP, 1, R2_B, 1);
    y = Y_TOP;
    v = 1;
    while (y + v < Y_HOR) begin
      y = y + v;
      v = (v + 1 > VMAX) ? VMAX : v + 1;
      add_pos(y, 1, R2_B, 1);
    end
    add_pos(Y_HOR, 0, R2_B, 2);
    for (int kk = 1; kk < PF; kk++)
      add_pos(Y_HOR, 0, R2_B + R2_S * ((kk <= PF / 2) ? kk : PF - kk), 2);
  endtask

  function automatic logic [58:0] model_word();
    return pack(m_frame % 65536, m_phase % 256, t_y[m_idx], t_vis[m_idx],
                t_r2[m_idx], t_st[m_idx]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic frame();
    repeat (6) @(posedge clk);
    #1;
    if (!m_pause || m_step_pend) begin
      m_frame = m_frame + 1;
      m_phase = m_phase + int'(speed_in) + 1;
      m_idx   = (m_idx + 1) % t_y.size();
    end
    m_step_pend = 1'b0;
    exp_q.push_back(model_word());
    vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1 vsync = 1'b1;
  endtask

  task automatic set_pause(bit p);
    @(posedge clk);
    #1 pause_in = p;
    m_pause = p;
  endtask

  task automatic pulse_step();
    @(posedge clk);
    #1 step_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 step_in = 1'b0;
    repeat (3) @(posedge clk);
    if (m_pause) m_step_pend = 1'b1;
  endtask

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_frame_tick"}, int'(seq_if.frame_tick), 0);
    check({tag, "_frame_cnt"}, int'(seq_if.frame_cnt), 0);
    check({tag, "_tex_phase"}, int'(seq_if.tex_phase), 0);
    check({tag, "_text_y"}, int'(seq_if.text_y), Y_TOP);
    check({tag, "_text_visible"}, int'(seq_if.text_visible), 1);
    check({tag, "_shadow_r2"}, int'(seq_if.shadow_r2), R2_B);
    check({tag, "_scene_state"}, int'(seq_if.scene_state), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  bit mon_on = 1'b0;
  bit prev_tick = 1'b0;

  always @(negedge clk) begin
    logic [58:0] exp_w;
    logic [58:0] act_w;
    if (mon_on && seq_if.frame_tick) begin
      tests++;
      if (prev_tick) begin
        fails++;
        $display("FAIL tick_width: frame_tick high on 2 consecutive cycles, required 1");
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tick: frame_tick with no vsync falling edge driven");
      end else begin
        exp_w = exp_q.pop_front();
        act_w = {seq_if.frame_cnt, seq_if.tex_phase, seq_if.text_y, seq_if.text_visible,
                 seq_if.shadow_r2, seq_if.scene_state};
        if (act_w !== exp_w) begin
          fails++;
          $display("FAIL frame_outputs: got cnt=%0d ph=%0d y=%0d vis=%0b r2=%0d st=%0d, required cnt=%0d ph=%0d y=%0d vis=%0b r2=%0d st=%0d",
                   act_w[58:43], act_w[42:35], act_w[34:25], act_w[24], act_w[23:2], act_w[1:0],
                   exp_w[58:43], exp_w[42:35], exp_w[34:25], exp_w[24], exp_w[23:2], exp_w[1:0]);
        end
      end
    end
    prev_tick = seq_if.frame_tick;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit did_freeze;
    bit reached;
    int r;

    build_table();
    m_idx = 0; m_frame = 0; m_phase = 0; m_pause = 0; m_step_pend = 0;
    did_freeze = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    mon_on = 1'b1;

    // Three frames at speed 0 stay in WAIT at the top.
    repeat (3) frame();
    @(negedge clk);
    check("after3_frame_cnt", int'(seq_if.frame_cnt), 3);
    check("after3_tex_phase", int'(seq_if.tex_phase), 3);
    check("after3_state", int'(seq_if.scene_state), 0);
    check("after3_text_y", int'(seq_if.text_y), Y_TOP);

    // Step while running must not add an extra advance.
    pulse_step();

    for (int n = 0; n < 200; n++) begin
      if (!did_freeze && !m_pause && t_st[m_idx] == 1 && t_y[m_idx] == 35) begin
        set_pause(1'b1);
        repeat (5) frame();
        pulse_step();
        frame();
        @(negedge clk);
        check("step_text_y", int'(seq_if.text_y), 41);
        set_pause(1'b0);
        did_freeze = 1'b1;
      end
      if (n >= 60) begin
        r = $urandom_range(0, 99);
        if (r < 12) set_pause(!m_pause);
        r = $urandom_range(0, 99);
        if (m_pause && r < 35) pulse_step();
        else if (!m_pause && r < 8) pulse_step();
      end
      if ($urandom_range(0, 99) < 20) begin
        @(posedge clk);
        #1 speed_in = 2'($urandom_range(0, 3));
      end
      frame();
    end
    check("freeze_scenario_reached", int'(did_freeze), 1);

    // Run into the swallow pulse, then reset in the middle of it.
    set_pause(1'b0);
    reached = 1'b0;
    for (int n = 0; n < 80 && !reached; n++) begin
      frame();
      if (t_st[m_idx] == 2 && t_r2[m_idx] > R2_B) reached = 1'b1;
    end
    check("swallow_reached", int'(reached), 1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    m_idx = 0; m_frame = 0; m_phase = 0; m_step_pend = 0;
    repeat (15) @(posedge clk);

    // Post-reset frames, including the speed 3 phase path.
    @(posedge clk);
    #1 speed_in = 2'd3;
    repeat (12) frame();

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
